// File: rtl/sar_logic_tscs_param.sv
// Two-step coarse/fine SAR control: the coarse array resolves K MSBs, then hands its code to the fine array,
// which resolves the remaining bits. The fine array can carry one redundant bit, corrected and clamped at the end.
module sar_logic_tscs_param #(
  parameter int N          = 10,
  parameter int K          = 7,
  parameter int SAMPLE_CYC = 4,
  parameter int REDUN      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cnvst,
  input  logic         cont,
  input  logic         coarse_cmp_out,
  input  logic         fine_cmp_out,
  output logic [N-1:0] sar,
  output logic         eoc,
  output logic         busy,
  output logic         s_clk,
  output logic         s_clk_not,
  output logic         coarse_cmp_clk,
  output logic         fine_cmp_clk,
  output logic [K-1:0] coarse_dac,
  output logic [K-1:0] fine_base,
  output logic [N-K:0] fine_res_dac
);

  localparam int M   = N - K + REDUN;
  localparam int CIW = $clog2(K);
  localparam int FIW = $clog2(N - K + 1);
  localparam int CW  = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SAMPLE, COARSE, XFER, FINE, DONE} state_t;

  state_t         state, state_n;
  logic           cnvst_q;
  logic [CW-1:0]  cnt, cnt_n;
  logic [CIW-1:0] cidx, cidx_n;
  logic [FIW-1:0] fidx, fidx_n;
  logic           phase, phase_n;

  logic [N-1:0]   sar_n;
  logic           eoc_n, busy_n, s_clk_n, s_clk_not_n, coarse_cmp_clk_n, fine_cmp_clk_n;
  logic [K-1:0]   coarse_dac_n, fine_base_n;
  logic [N-K:0]   fine_res_dac_n;

  logic [N-K:0]   fine_fin;
  logic [N+1:0]   c_ext, half, raw;
  logic [N-1:0]   corr;

  // Final fine code includes the decision arriving in the last phase B; the redundant
  // half-LSB offset can push the sum below zero or above full scale, hence the clamp.
  always_comb begin
    fine_fin    = fine_res_dac;
    fine_fin[0] = fine_cmp_out;
    c_ext       = (N+2)'(fine_base) << (N - K);
    half        = (REDUN != 0) ? ((N+2)'(1) << (N - K - 1)) : '0;
    raw         = c_ext + (N+2)'(fine_fin) - half;
    if (raw[N+1])
      corr = '0;
    else if (raw[N])
      corr = '1;
    else
      corr = raw[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnvst_q        <= 1'b0;
      cnt            <= '0;
      cidx           <= '0;
      fidx           <= '0;
      phase          <= 1'b0;
      sar            <= '0;
      eoc            <= 1'b0;
      busy           <= 1'b0;
      s_clk          <= 1'b0;
      s_clk_not      <= 1'b1;
      coarse_cmp_clk <= 1'b0;
      fine_cmp_clk   <= 1'b0;
      coarse_dac     <= '0;
      fine_base      <= '0;
      fine_res_dac   <= '0;
    end else begin
      state          <= state_n;
      cnvst_q        <= cnvst;
      cnt            <= cnt_n;
      cidx           <= cidx_n;
      fidx           <= fidx_n;
      phase          <= phase_n;
      sar            <= sar_n;
      eoc            <= eoc_n;
      busy           <= busy_n;
      s_clk          <= s_clk_n;
      s_clk_not      <= s_clk_not_n;
      coarse_cmp_clk <= coarse_cmp_clk_n;
      fine_cmp_clk   <= fine_cmp_clk_n;
      coarse_dac     <= coarse_dac_n;
      fine_base      <= fine_base_n;
      fine_res_dac   <= fine_res_dac_n;
    end
  end

  // Outputs are registered copies of what the next state implies, so every strobe is glitch-free.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    cidx_n         = cidx;
    fidx_n         = fidx;
    phase_n        = phase;
    sar_n          = sar;
    coarse_dac_n   = coarse_dac;
    fine_base_n    = fine_base;
    fine_res_dac_n = fine_res_dac;

    case (state)
      IDLE: begin
        if (cnvst && !cnvst_q)
          state_n = SAMPLE;
      end
      SAMPLE: begin
        if (cnt == CW'(SAMPLE_CYC - 1)) begin
          state_n         = COARSE;
          cidx_n          = CIW'(K - 1);
          phase_n         = 1'b0;
          coarse_dac_n[K-1] = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      COARSE: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          coarse_dac_n[cidx] = coarse_cmp_out;
          phase_n            = 1'b0;
          if (cidx == '0) begin
            state_n = XFER;
          end else begin
            cidx_n               = cidx - CIW'(1);
            coarse_dac_n[cidx_n] = 1'b1;
          end
        end
      end
      XFER: begin
        fine_base_n         = coarse_dac;
        state_n             = FINE;
        fidx_n              = FIW'(M - 1);
        phase_n             = 1'b0;
        fine_res_dac_n[M-1] = 1'b1;
      end
      FINE: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          fine_res_dac_n[fidx] = fine_cmp_out;
          phase_n              = 1'b0;
          if (fidx == '0) begin
            state_n = DONE;
            sar_n   = corr;
          end else begin
            fidx_n                 = fidx - FIW'(1);
            fine_res_dac_n[fidx_n] = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = cont ? SAMPLE : IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (state_n == SAMPLE && state != SAMPLE) begin
      cnt_n          = '0;
      coarse_dac_n   = '0;
      fine_base_n    = '0;
      fine_res_dac_n = '0;
    end

    s_clk_n          = (state_n == SAMPLE);
    s_clk_not_n      = (state_n != SAMPLE);
    busy_n           = (state_n != IDLE);
    eoc_n            = (state_n == DONE);
    coarse_cmp_clk_n = (state_n == COARSE) && !phase_n;
    fine_cmp_clk_n   = (state_n == FINE) && !phase_n;
  end

endmodule

// File: tb/tb_sar_logic_tscs_param.sv
// Scoreboard bench for sar_logic_tscs_param: lane 0 uses the redundant fine stage, lane 1 the plain one.
// Comparator decisions come from per-lane bit queues; expected codes come from the correction arithmetic.
module tb_sar_logic_tscs_param;
  localparam int N  = 10;
  localparam int K  = 7;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst;
  logic cnvst [2];
  logic cont  [2];
  logic ccmp  [2];
  logic fcmp  [2];

  logic [N-1:0] sar       [2];
  logic         eoc       [2];
  logic         busy      [2];
  logic         s_clk     [2];
  logic         s_clk_not [2];
  logic         cclk      [2];
  logic         fclk      [2];
  logic [K-1:0] cdac      [2];
  logic [K-1:0] fbase     [2];
  logic [N-K:0] fres      [2];

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  int exp_q [2][$];
  bit cbits [2][$];
  bit fbits [2][$];
  int eoc_t [2][$];
  int eoc_cnt  [2];
  int conv_cnt [2];
  bit inv_bad  [2];

  sar_logic_tscs_param #(.N(N), .K(K), .SAMPLE_CYC(SC), .REDUN(1)) dut_r1 (
    .clk(clk), .rst(rst), .cnvst(cnvst[0]), .cont(cont[0]),
    .coarse_cmp_out(ccmp[0]), .fine_cmp_out(fcmp[0]),
    .sar(sar[0]), .eoc(eoc[0]), .busy(busy[0]), .s_clk(s_clk[0]), .s_clk_not(s_clk_not[0]),
    .coarse_cmp_clk(cclk[0]), .fine_cmp_clk(fclk[0]),
    .coarse_dac(cdac[0]), .fine_base(fbase[0]), .fine_res_dac(fres[0])
  );

  sar_logic_tscs_param #(.N(N), .K(K), .SAMPLE_CYC(SC), .REDUN(0)) dut_r0 (
    .clk(clk), .rst(rst), .cnvst(cnvst[1]), .cont(cont[1]),
    .coarse_cmp_out(ccmp[1]), .fine_cmp_out(fcmp[1]),
    .sar(sar[1]), .eoc(eoc[1]), .busy(busy[1]), .s_clk(s_clk[1]), .s_clk_not(s_clk_not[1]),
    .coarse_cmp_clk(cclk[1]), .fine_cmp_clk(fclk[1]),
    .coarse_dac(cdac[1]), .fine_base(fbase[1]), .fine_res_dac(fres[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int mOf(input int ln);
    return N - K + ((ln == 0) ? 1 : 0);
  endfunction

  function automatic int latOf(input int ln);
    return SC + 2 * K + 1 + 2 * mOf(ln) + 1;
  endfunction

  // Reference: code value C scaled to N bits, minus half a coarse LSB when redundant, plus F, clamped.
  function automatic int modelSar(input int c, input int f, input bit redun);
    int lsb_w;
    int r;
    lsb_w = 1 << (N - K);
    r = c * lsb_w + f - (redun ? lsb_w / 2 : 0);
    if (r < 0) r = 0;
    if (r > (1 << N) - 1) r = (1 << N) - 1;
    return r;
  endfunction

  function automatic logic [63:0] packOuts(input int ln);
    return 64'({sar[ln], fres[ln], fbase[ln], cdac[ln], eoc[ln], busy[ln], s_clk[ln],
                cclk[ln], fclk[ln], s_clk_not[ln]});
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Answers comparator strobes from the decision queues and scores every eoc against the queue head.
  task automatic monitor(input int ln);
    int first_s = 0;
    bit s_prev = 1'b0;
    int want;
    forever begin
      @(negedge clk);
      if (rst) begin
        cbits[ln].delete();
        fbits[ln].delete();
      end
      if (cclk[ln]) ccmp[ln] = (cbits[ln].size() > 0) ? cbits[ln].pop_front() : 1'b0;
      if (fclk[ln]) fcmp[ln] = (fbits[ln].size() > 0) ? fbits[ln].pop_front() : 1'b0;
      if ((s_clk_not[ln] == s_clk[ln]) || (cclk[ln] && fclk[ln]) ||
          (s_clk[ln] && (cclk[ln] || fclk[ln])) || (eoc[ln] && !busy[ln]))
        inv_bad[ln] = 1'b1;
      if (s_clk[ln] && !s_prev) first_s = cycle;
      s_prev = s_clk[ln];
      if (eoc[ln]) begin
        eoc_cnt[ln]++;
        eoc_t[ln].push_back(cycle);
        if (exp_q[ln].size() == 0) begin
          checkOutput($sformatf("lane%0d_unexpected_eoc", ln), 64'd1, 64'd0);
        end else begin
          want = exp_q[ln].pop_front();
          checkOutput($sformatf("lane%0d_sar", ln), 64'(sar[ln]), 64'(want));
          // inclusive count: first s_clk cycle through the eoc cycle
          checkOutput($sformatf("lane%0d_latency", ln), 64'(cycle - first_s + 1), 64'(latOf(ln)));
        end
      end
    end
  endtask

  task automatic queueConv(input int ln, input int c, input int f);
    for (int i = K - 1; i >= 0; i--) cbits[ln].push_back(c[i]);
    for (int j = mOf(ln) - 1; j >= 0; j--) fbits[ln].push_back(f[j]);
    exp_q[ln].push_back(modelSar(c, f, ln == 0));
    conv_cnt[ln]++;
  endtask

  task automatic waitEoc(input int ln, input int target, input int budget);
    int n = 0;
    while (eoc_cnt[ln] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("lane%0d_eoc_arrived", ln), 64'(eoc_cnt[ln] >= target), 64'd1);
  endtask

  task automatic applyStimulus(input int ln, input int c, input int f, input bit hold, input bit poke);
    int start;
    queueConv(ln, c, f);
    start = eoc_cnt[ln];
    @(negedge clk);
    cnvst[ln] = 1'b1;
    if (!hold) begin
      @(negedge clk);
      cnvst[ln] = 1'b0;
      if (poke) begin
        repeat (8) @(negedge clk);
        cnvst[ln] = 1'b1;
        @(negedge clk);
        cnvst[ln] = 1'b0;
      end
    end
    waitEoc(ln, start + 1, 100);
    repeat (6) @(negedge clk);
    cnvst[ln] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int start;
    int strobes;
    int n;
    int sz;
    rst = 1'b1;
    for (int l = 0; l < 2; l++) begin
      cnvst[l] = 1'b0; cont[l] = 1'b0; ccmp[l] = 1'b0; fcmp[l] = 1'b0;
      eoc_cnt[l] = 0; conv_cnt[l] = 0; inv_bad[l] = 1'b0;
    end
    fork
      monitor(0);
      monitor(1);
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("lane0_reset_state", packOuts(0), 64'd1);
    checkOutput("lane1_reset_state", packOuts(1), 64'd1);

    applyStimulus(0, 85, 6, 1'b1, 1'b0);
    applyStimulus(0, 127, 15, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1, 85, 6, 1'b0, 1'b0);
    applyStimulus(1, 127, 7, 1'b0, 1'b0);
    applyStimulus(1, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) queueConv(0, $urandom_range(0, 127), $urandom_range(0, 15));
    start = eoc_cnt[0];
    cont[0] = 1'b1;
    @(negedge clk);
    cnvst[0] = 1'b1;
    @(negedge clk);
    cnvst[0] = 1'b0;
    waitEoc(0, start + 2, 120);
    repeat (2) @(negedge clk);
    cont[0] = 1'b0;
    waitEoc(0, start + 3, 60);
    repeat (3) @(negedge clk);
    checkOutput("cont_back_to_idle", 64'(busy[0]), 64'd0);
    sz = eoc_t[0].size();
    checkOutput("cont_period_1", 64'(eoc_t[0][sz-2] - eoc_t[0][sz-3]), 64'(latOf(0)));
    checkOutput("cont_period_2", 64'(eoc_t[0][sz-1] - eoc_t[0][sz-2]), 64'(latOf(0)));

    @(negedge clk);
    cnvst[0] = 1'b1;
    @(negedge clk);
    cnvst[0] = 1'b0;
    strobes = 0;
    n = 0;
    while (strobes < 4 && n < 100) begin
      if (cclk[0]) strobes++;
      if (strobes < 4) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("abort_reached_bit3", 64'(strobes), 64'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_reset_state", packOuts(0), 64'd1);
    repeat (3) @(negedge clk);
    applyStimulus(0, 42, 9, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int ln;
      ln = i % 2;
      applyStimulus(ln, $urandom_range(0, 127), $urandom_range(0, (1 << mOf(ln)) - 1),
                    1'b0, (i % 3) == 0);
    end

    repeat (40) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      checkOutput($sformatf("lane%0d_eoc_count", l), 64'(eoc_cnt[l]), 64'(conv_cnt[l]));
      checkOutput($sformatf("lane%0d_invariants", l), 64'(inv_bad[l]), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
